// File: rtl/hvac_zone_ctrl.sv
// Single-zone heat/cool controller: run-time setpoint and mode, hysteresis band,
// minimum dwell between threshold-driven transitions, and a stale-sensor fault state.
module hvac_zone_ctrl #(
  parameter int TEMP_W    = 5,
  parameter int HYST      = 2,
  parameter int MIN_DWELL = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TEMP_W-1:0] temperature,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] setpoint,
  input  logic [1:0]        mode,
  output logic              heating,
  output logic              cooling,
  output logic              fault,
  output logic [1:0]        state
);

  localparam int TW   = TEMP_W + 1;
  localparam int DW_W = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
  localparam int SW_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [TW-1:0]   HYST_X    = TW'(HYST);
  localparam logic [TW-1:0]   T_MAX     = {1'b0, {TEMP_W{1'b1}}};
  localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(MIN_DWELL);
  localparam logic [SW_W-1:0] STALE_MAX = SW_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_HEAT  = 2'b01,
    S_COOL  = 2'b10,
    S_FAULT = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [TEMP_W-1:0] temp_q;
  logic              seen_q;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [SW_W-1:0]   stale_q, stale_d;

  logic [TW-1:0] sp_x, tq_x, lo, hi, hi_sum;
  logic          dwell_ok, stale_hit;

  // Thresholds carry one extra bit so the band clamps instead of wrapping.
  assign sp_x      = {1'b0, setpoint};
  assign tq_x      = {1'b0, temp_q};
  assign lo        = (sp_x >= HYST_X) ? (sp_x - HYST_X) : '0;
  assign hi_sum    = sp_x + HYST_X;
  assign hi        = (hi_sum > T_MAX) ? T_MAX : hi_sum;
  assign dwell_ok  = (dwell_q == DWELL_MAX);
  assign stale_hit = (TIMEOUT != 0) && (stale_q == STALE_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      temp_q  <= '0;
      seen_q  <= 1'b0;
      dwell_q <= DWELL_MAX;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      stale_q <= stale_d;
      if (temp_valid) begin
        temp_q <= temperature;
        seen_q <= 1'b1;
      end
    end
  end

  always_comb begin
    stale_d = stale_q;
    if (temp_valid) begin
      stale_d = '0;
    end else if (stale_q != STALE_MAX) begin
      stale_d = stale_q + SW_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (stale_hit && (state_q != S_FAULT)) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_FAULT: if (temp_valid) state_d = S_IDLE;
        S_IDLE: begin
          if (seen_q && dwell_ok) begin
            if ((tq_x <= lo) && mode[0]) begin
              state_d = S_HEAT;
            end else if ((tq_x >= hi) && mode[1]) begin
              state_d = S_COOL;
            end
          end
        end
        // Losing the enable bit for the active direction covers every forced-off mode.
        S_HEAT: begin
          if (!mode[0]) begin
            state_d = S_IDLE;
          end else if ((tq_x >= sp_x) && dwell_ok) begin
            state_d = S_IDLE;
          end
        end
        S_COOL: begin
          if (!mode[1]) begin
            state_d = S_IDLE;
          end else if ((tq_x <= sp_x) && dwell_ok) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    dwell_d = dwell_q;
    if (state_d != state_q) begin
      dwell_d = '0;
    end else if (dwell_q != DWELL_MAX) begin
      dwell_d = dwell_q + DW_W'(1);
    end
  end

  assign heating = (state_q == S_HEAT);
  assign cooling = (state_q == S_COOL);
  assign fault   = (state_q == S_FAULT);
  assign state   = state_q;

endmodule

// File: tb/tb_hvac_zone_ctrl.sv
// Bench for hvac_zone_ctrl (default parameters): per-cycle vector table with
// expected state queued at drive time and compared after the clock edge.
module tb_hvac_zone_ctrl;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] HEAT = 2'b01;
  localparam logic [1:0] COOL = 2'b10;
  localparam logic [1:0] FLT  = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] temperature;
  logic       temp_valid;
  logic [4:0] setpoint;
  logic [1:0] mode;
  logic       heating, cooling, fault;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    bit          rst_before;
    logic [4:0]  temp;
    logic        valid;
    logic [4:0]  sp;
    logic [1:0]  mode;
    int unsigned reps;
    logic [1:0]  exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [1:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  hvac_zone_ctrl #(.TEMP_W(5), .HYST(2), .MIN_DWELL(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .temperature(temperature),
    .temp_valid (temp_valid),
    .setpoint   (setpoint),
    .mode       (mode),
    .heating    (heating),
    .cooling    (cooling),
    .fault      (fault),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] exp);
    logic [4:0] act, req;
    act = {state, heating, cooling, fault};
    req = {exp, exp == HEAT, exp == COOL, exp == FLT};
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got state=%0d heat=%0b cool=%0b fault=%0b, expected state=%0d heat=%0b cool=%0b fault=%0b",
               name, act[4:3], act[2], act[1], act[0], req[4:3], req[2], req[1], req[0]);
    end
  endtask

  task automatic add_vec(input string name, input bit r, input logic [4:0] t, input logic v,
                         input logic [4:0] s, input logic [1:0] m, input int unsigned n,
                         input logic [1:0] e);
    vec_t x;
    x.name = name; x.rst_before = r; x.temp = t; x.valid = v;
    x.sp = s; x.mode = m; x.reps = n; x.exp = e;
    vecs.push_back(x);
  endtask

  task automatic drive_step(input string name, input logic [4:0] t, input logic v,
                            input logic [4:0] s, input logic [1:0] m, input logic [1:0] e);
    sb_t r;
    temperature = t;
    temp_valid  = v;
    setpoint    = s;
    mode        = m;
    sb.push_back('{name, e});
    @(posedge clk);
    #1;
    r = sb.pop_front();
    check(r.name, r.exp);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    temp_valid = 1'b0;
    #2;
    check("reset_state", IDLE);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if (heating && cooling) begin
        n_bad++;
        $display("FAIL heat_cool_overlap: heat=%0b cool=%0b, expected never both 1", heating, cooling);
      end
    end
  end

  initial begin
    temperature = '0;
    temp_valid  = 1'b0;
    setpoint    = 5'd20;
    mode        = 2'b11;
    #1;

    // heat from cold start, ramp +1 per two cycles
    add_vec("s1_first_sample", 1, 5'd16, 1, 5'd20, 2'b11, 1, IDLE);
    add_vec("s1_heat_on",      0, 5'd16, 1, 5'd20, 2'b11, 1, HEAT);
    add_vec("s1_ramp17",       0, 5'd17, 1, 5'd20, 2'b11, 2, HEAT);
    add_vec("s1_ramp18",       0, 5'd18, 1, 5'd20, 2'b11, 2, HEAT);
    add_vec("s1_ramp19",       0, 5'd19, 1, 5'd20, 2'b11, 2, HEAT);
    add_vec("s1_ramp20",       0, 5'd20, 1, 5'd20, 2'b11, 1, HEAT);
    add_vec("s1_heat_off",     0, 5'd20, 1, 5'd20, 2'b11, 1, IDLE);
    add_vec("s1_idle_hold",    0, 5'd20, 1, 5'd20, 2'b11, 3, IDLE);
    // dwell holds HEAT although setpoint already reached
    add_vec("s1b_sample",      1, 5'd18, 1, 5'd20, 2'b11, 1, IDLE);
    add_vec("s1b_heat_on",     0, 5'd18, 1, 5'd20, 2'b11, 1, HEAT);
    add_vec("s1b_ramp19",      0, 5'd19, 1, 5'd20, 2'b11, 2, HEAT);
    add_vec("s1b_dwell_hold",  0, 5'd20, 1, 5'd20, 2'b11, 2, HEAT);
    add_vec("s1b_heat_off",    0, 5'd20, 1, 5'd20, 2'b11, 1, IDLE);
    // cool, dwell in COOL and IDLE, then heat
    add_vec("s2_sample",       1, 5'd23, 1, 5'd20, 2'b11, 1, IDLE);
    add_vec("s2_cool_on",      0, 5'd23, 1, 5'd20, 2'b11, 1, COOL);
    add_vec("s2_cool_dwell",   0, 5'd19, 1, 5'd20, 2'b11, 4, COOL);
    add_vec("s2_cool_off",     0, 5'd19, 1, 5'd20, 2'b11, 1, IDLE);
    add_vec("s2_idle_dwell",   0, 5'd17, 1, 5'd20, 2'b11, 4, IDLE);
    add_vec("s2_heat_on",      0, 5'd17, 1, 5'd20, 2'b11, 1, HEAT);
    // mode restrictions and forced off
    add_vec("s3_heat_only",    1, 5'd25, 1, 5'd20, 2'b01, 3, IDLE);
    add_vec("s3_cool_only",    0, 5'd25, 1, 5'd20, 2'b10, 2, COOL);
    add_vec("s3_off_forced",   0, 5'd25, 1, 5'd20, 2'b00, 1, IDLE);
    add_vec("s3_off_hold",     0, 5'd5,  1, 5'd20, 2'b00, 3, IDLE);
    // stale sensor fault and recovery
    add_vec("s4_sample",       1, 5'd16, 1, 5'd20, 2'b11, 1, IDLE);
    add_vec("s4_heat_on",      0, 5'd16, 1, 5'd20, 2'b11, 1, HEAT);
    add_vec("s4_stale_count",  0, 5'd16, 0, 5'd20, 2'b11, 16, HEAT);
    add_vec("s4_fault",        0, 5'd16, 0, 5'd20, 2'b11, 2, FLT);
    add_vec("s4_recover",      0, 5'd20, 1, 5'd20, 2'b11, 1, IDLE);
    add_vec("s4_after",        0, 5'd20, 1, 5'd20, 2'b11, 2, IDLE);
    // threshold clamping at both ends of the range
    add_vec("s5_lo_sample",    1, 5'd0,  1, 5'd1,  2'b11, 1, IDLE);
    add_vec("s5_lo_heat",      0, 5'd0,  1, 5'd1,  2'b11, 1, HEAT);
    add_vec("s5_heat_forced",  0, 5'd5,  1, 5'd1,  2'b10, 1, IDLE);
    add_vec("s5_lo_nowrap",    0, 5'd5,  1, 5'd1,  2'b11, 4, IDLE);
    add_vec("s5_lo_cool",      0, 5'd5,  1, 5'd1,  2'b11, 1, COOL);
    add_vec("s5_hi_below",     1, 5'd30, 1, 5'd31, 2'b10, 2, IDLE);
    add_vec("s5_hi_sample",    0, 5'd31, 1, 5'd31, 2'b10, 1, IDLE);
    add_vec("s5_hi_cool",      0, 5'd31, 1, 5'd31, 2'b10, 1, COOL);

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      for (int unsigned k = 0; k < vecs[i].reps; k++) begin
        drive_step(vecs[i].name, vecs[i].temp, vecs[i].valid, vecs[i].sp, vecs[i].mode, vecs[i].exp);
      end
    end

    // asynchronous reset between edges while cooling
    do_reset();
    drive_step("s6_sample",       5'd25, 1'b1, 5'd20, 2'b11, IDLE);
    drive_step("s6_cool_on",      5'd25, 1'b1, 5'd20, 2'b11, COOL);
    drive_step("s6_cool_hold",    5'd25, 1'b1, 5'd20, 2'b11, COOL);
    #2;
    rst = 1'b1;
    #1;
    check("s6_async_reset", IDLE);
    @(negedge clk);
    rst = 1'b0;
    drive_step("s6_resample",     5'd25, 1'b1, 5'd20, 2'b11, IDLE);
    drive_step("s6_cool_nodelay", 5'd25, 1'b1, 5'd20, 2'b11, COOL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
